// File: rtl/img_pkg.sv
// Shared defaults and state type for the packed-pixel unpacker.
// Imported by img_pos_cnt and img_stream_unpack.
package img_pkg;

    localparam int PIX_W_DEF        = 8;
    localparam int PIX_PER_BEAT_DEF = 4;
    localparam int DIM_W_DEF        = 12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/img_pos_cnt.sv
// Column/row position tracker for one frame of pixels.
// Ports: clk_i, rst_i (async, high), clr_i (restart at 0,0), adv_i (one
// pixel transferred), width_i/height_i (frame size), sof_o (at 0,0),
// eol_o (last column), frame_end_o (last column of last row).
module img_pos_cnt
    import img_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    output logic             sof_o,
    output logic             eol_o,
    output logic             frame_end_o
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic             last_row;

    assign eol_o       = (col_q == width_i - DIM_W'(1));
    assign last_row    = (row_q == height_i - DIM_W'(1));
    assign sof_o       = (col_q == '0) && (row_q == '0);
    assign frame_end_o = eol_o && last_row;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/img_stream_unpack.sv
// Unpacks a DMA stream of PIX_PER_BEAT-pixel beats into a 1-pixel stream
// with SOF (m_tuser) and EOL (m_tlast) markers for a fixed-size frame.
// Ports: role_clk/role_rst (async, high); cfg_width/cfg_height/start
// frame setup; busy; s_* packed input stream; m_* pixel output stream;
// err/err_clr sticky framing error. Define IMG_UNPACK_ERR_EN to enable
// s_tlast checking; otherwise err is tied low.
module img_stream_unpack
    import img_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int PIX_PER_BEAT = PIX_PER_BEAT_DEF,
    parameter int DIM_W        = DIM_W_DEF
) (
    input  logic                          role_clk,
    input  logic                          role_rst,
    input  logic [DIM_W-1:0]              cfg_width,
    input  logic [DIM_W-1:0]              cfg_height,
    input  logic                          start,
    output logic                          busy,
    input  logic [PIX_W*PIX_PER_BEAT-1:0] s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic                          s_tready,
    output logic [PIX_W-1:0]              m_tdata,
    output logic                          m_tvalid,
    output logic                          m_tuser,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic                          err,
    input  logic                          err_clr
);

    localparam int BEAT_W = PIX_W * PIX_PER_BEAT;
    localparam int IDX_W  = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
    localparam int CNT_W  = 2 * DIM_W;

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   width_q, width_d;
    logic [DIM_W-1:0]   height_q, height_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               full_q, full_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic cfg_ok, start_ok, last_pix, xfer, accept, done;
    logic sof, eol, frame_end;

    assign cfg_ok   = (cfg_width != '0) && (cfg_height != '0) &&
                      ((cfg_width % DIM_W'(PIX_PER_BEAT)) == '0);
    assign start_ok = (state_q == S_IDLE) && start && cfg_ok;
    assign last_pix = (idx_q == IDX_W'(PIX_PER_BEAT - 1));

    assign m_tvalid = full_q;
    assign m_tdata  = beat_q[PIX_W-1:0];
    assign m_tuser  = full_q && sof;
    assign m_tlast  = full_q && eol;
    assign busy     = (state_q == S_RUN);

    assign xfer     = m_tvalid && m_tready;
    assign done     = xfer && frame_end;
    // Refill in the same cycle the last pixel leaves: no bubble between
    // beats. beats_q stops intake once the frame's beats are all in.
    assign s_tready = (state_q == S_RUN) && (beats_q != '0) &&
                      (!full_q || (xfer && last_pix));
    assign accept   = s_tvalid && s_tready;

    img_pos_cnt #(
        .DIM_W (DIM_W)
    ) u_pos (
        .clk_i       (role_clk),
        .rst_i       (role_rst),
        .clr_i       (start_ok),
        .adv_i       (xfer),
        .width_i     (width_q),
        .height_i    (height_q),
        .sof_o       (sof),
        .eol_o       (eol),
        .frame_end_o (frame_end)
    );

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        height_d = height_q;
        beats_d  = beats_q;
        beat_d   = beat_q;
        full_d   = full_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d  = S_RUN;
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    beats_d  = CNT_W'(cfg_width / DIM_W'(PIX_PER_BEAT)) *
                               CNT_W'(cfg_height);
                    full_d   = 1'b0;
                    idx_d    = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    beat_d = beat_q >> PIX_W;
                    idx_d  = idx_q + IDX_W'(1);
                    if (last_pix) begin
                        full_d = 1'b0;
                        idx_d  = '0;
                    end
                end
                if (accept) begin
                    beat_d  = s_tdata;
                    full_d  = 1'b1;
                    idx_d   = '0;
                    beats_d = beats_q - CNT_W'(1);
                end
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge role_clk or posedge role_rst) begin
        if (role_rst) begin
            state_q  <= S_IDLE;
            width_q  <= '0;
            height_q <= '0;
            beats_q  <= '0;
            beat_q   <= '0;
            full_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            height_q <= height_d;
            beats_q  <= beats_d;
            beat_q   <= beat_d;
            full_q   <= full_d;
            idx_q    <= idx_d;
        end
    end

`ifdef IMG_UNPACK_ERR_EN
    logic err_q, err_d, last_beat, err_hit;

    assign last_beat = (beats_q == CNT_W'(1));
    assign err_hit   = accept && (s_tlast != last_beat);

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (err_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge role_clk or posedge role_rst) begin
        if (role_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = ^{s_tlast, err_clr};
    assign err        = 1'b0;
`endif

endmodule

// File: doc/img_stream_unpack.md
IMG_STREAM_UNPACK -- requirements
Module: img_stream_unpack

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-002 SHALL have parameter PIX_PER_BEAT, default 4, pixels packed per input beat.
REQ-003 SHALL have parameter DIM_W, default 12, width of dimension and counter fields.
REQ-004 SHALL have port role_clk  input  1  sole clock.
REQ-005 SHALL have port role_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_width  input  DIM_W  pixels per line.
REQ-007 SHALL have port cfg_height  input  DIM_W  lines per frame.
REQ-008 SHALL have port start  input  1  single-cycle frame start pulse.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have ports s_tdata/s_tvalid/s_tlast (input, PIX_W*PIX_PER_BEAT/1/1) and s_tready (output, 1); packed DMA stream, pixel 0 in LSBs.
REQ-011 SHALL have ports m_tdata/m_tvalid/m_tuser/m_tlast (output, PIX_W/1/1/1) and m_tready (input, 1); pixel stream to role core, tuser=SOF, tlast=EOL.
REQ-012 SHALL have ports err (output, 1, sticky framing error) and err_clr (input, 1).

Function
REQ-013 SHALL implement states IDLE, RUN. IDLE->RUN on start when cfg_width, cfg_height nonzero and cfg_width a multiple of PIX_PER_BEAT; otherwise start is ignored.
REQ-014 SHALL latch cfg_width/cfg_height on accepted start; later cfg changes have no effect until the next frame.
REQ-015 SHALL ignore start while in RUN.
REQ-016 SHALL hold s_tready=0 and m_tvalid=0 in IDLE; busy=1 exactly while in RUN.
REQ-017 SHALL hold one beat register; s_tready=1 in RUN when the register is empty or its last pixel is transferred in the same cycle (1 pixel/cycle sustained, no bubble).
REQ-018 SHALL assert m_tvalid the cycle after a beat is accepted (1-cycle latency) and emit pixels LSB-first, advancing one pixel per m_tvalid&m_tready.
REQ-019 SHALL keep m_tdata/m_tuser/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-020 SHALL assert m_tuser only on pixel (row 0, col 0) and m_tlast on col=width-1 of every line.
REQ-021 SHALL wrap col to 0 and increment row at line end; on transfer of (height-1, width-1), return to IDLE; busy deasserts the following cycle; no further beats are accepted.
REQ-022 SHALL not accept input beats beyond the frame's width*height/PIX_PER_BEAT beats.

Reset
REQ-023 SHALL on role_rst force state IDLE, counters 0, beat register empty, and all outputs (busy, s_tready, m_tvalid, m_tdata, m_tuser, m_tlast, err) to 0, asynchronously.
REQ-024 SHALL on reset mid-frame discard the partial frame; the next start begins a fresh frame with SOF.

Configuration
REQ-025 SHALL, with IMG_UNPACK_ERR_EN defined, set err when an accepted beat has s_tlast differing from "last beat of frame"; err stays set until err_clr (err_clr wins over a simultaneous new error only if no error occurs that cycle; simultaneous error keeps err=1); pixel flow is unaffected.
REQ-026 SHALL, without IMG_UNPACK_ERR_EN, tie err to 0, ignore s_tlast and err_clr, and contain no comparison logic.

Structure
REQ-027 SHALL place PIX_W, PIX_PER_BEAT, DIM_W defaults and the state enum typedef in shared package img_pkg.
REQ-028 SHALL implement col/row counting with wrap and frame-end flag in sub-module img_pos_cnt.

Verification
REQ-029 SHALL cover: width=8, height=2, start, 4 beats 0x03020100..., m_tready=1 -> 16 pixels 0x00..0x0F, one per cycle, tuser on pixel 0, tlast on pixels 7 and 15, busy low after.
REQ-030 SHALL cover: same frame, m_tready toggling 1/0 -> identical pixel sequence, outputs stable during stalls, no beat lost.
REQ-031 SHALL cover: cfg_width=6 or cfg_height=0 with start -> stays IDLE, busy=0, s_tready=0.
REQ-032 SHALL cover: role_rst asserted after 5 pixels of width=8 frame -> all outputs 0 immediately; new start yields SOF on first pixel.
REQ-033 SHALL cover (IMG_UNPACK_ERR_EN): s_tlast on beat 2 of 4 -> err=1 and held; err_clr pulse -> err=0; without macro err stays 0.
REQ-034 SHALL cover: start pulse while busy with different cfg -> ignored, frame completes with original dimensions.
